// File: rtl/ccff_pkg.sv
// ccff_pkg: types and constants shared by the configuration-chain loader.
//   ccff_state_e : loader FSM state encoding
//   CCFF_WORD_W  : default host word width in bits
package ccff_pkg;

    localparam int CCFF_WORD_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } ccff_state_e;

endpackage

// File: rtl/ccff_piso.sv
// ccff_piso: parallel-load, right-shift word register feeding the serial chain.
//   prog_clk : clock (rising edge)
//   pReset   : synchronous active-low reset, clears the register
//   load     : capture d (has priority over shift)
//   shift    : shift right by one, zero fill from the top
//   d        : parallel word in
//   q        : current LSB, the next bit to go out
module ccff_piso
    import ccff_pkg::*;
#(
    parameter int WORD_W = CCFF_WORD_W
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              load,
    input  logic              shift,
    input  logic [WORD_W-1:0] d,
    output logic              q
);

    logic [WORD_W-1:0] sr;

    always_ff @(posedge prog_clk) begin
        if (!pReset)
            sr <= '0;
        else if (load)
            sr <= d;
        else if (shift)
            sr <= {1'b0, sr[WORD_W-1:1]};
    end

    assign q = sr[0];

endmodule

// File: rtl/ccff_loader.sv
// ccff_loader: accepts host words and serialises them LSB first into a
// configuration flip-flop chain of CHAIN_LEN bits.
//   prog_clk  : clock (rising edge)
//   pReset    : synchronous active-low reset
//   start     : begin a load (honoured only when idle)
//   abort     : terminate an in-progress load
//   cfg_valid : host word valid
//   cfg_data  : host word
//   cfg_ready : loader takes a word this cycle
//   ccff_head : serial bit into the first tile
//   ccff_tail : bit back from the last tile, monitored only
//   shift_en  : chain advances on this edge
//   busy      : not idle
//   done      : one-cycle pulse on successful completion
//   aborted   : one-cycle pulse after an abort
module ccff_loader
    import ccff_pkg::*;
#(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = CCFF_WORD_W
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              abort,
    input  logic              cfg_valid,
    input  logic [WORD_W-1:0] cfg_data,
    output logic              cfg_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              shift_en,
    output logic              busy,
    output logic              done,
    output logic              aborted
);

    // Total-bit counter must hold CHAIN_LEN itself; the per-word counter
    // only ever reaches WORD_W-1 before the FSM leaves SHIFT.
    localparam int CW  = $clog2(CHAIN_LEN + 1);
    localparam int WCW = $clog2(WORD_W);

    ccff_state_e    state, state_nxt;
    logic [CW-1:0]  bit_cnt, bit_cnt_nxt;
    logic [WCW-1:0] word_bits, word_bits_nxt;
    logic           aborted_q, aborted_nxt;
    logic           piso_load, piso_shift, piso_q;

    // The tail is observed by external monitors only.
    logic unused_tail;
    assign unused_tail = ccff_tail;

    ccff_piso #(.WORD_W(WORD_W)) u_piso (
        .prog_clk (prog_clk),
        .pReset   (pReset),
        .load     (piso_load),
        .shift    (piso_shift),
        .d        (cfg_data),
        .q        (piso_q)
    );

    always_ff @(posedge prog_clk) begin
        if (!pReset) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            word_bits <= '0;
            aborted_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            word_bits <= word_bits_nxt;
            aborted_q <= aborted_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        word_bits_nxt = word_bits;
        aborted_nxt   = 1'b0;
        piso_load     = 1'b0;
        piso_shift    = 1'b0;
        cfg_ready     = 1'b0;
        shift_en      = 1'b0;
        ccff_head     = 1'b0;
        done          = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt   = ST_FETCH;
                    bit_cnt_nxt = '0;
                end
            end

            ST_FETCH: begin
                cfg_ready = 1'b1;
                // Abort wins over a coincident handshake: the word is dropped.
                if (abort) begin
                    state_nxt   = ST_IDLE;
                    aborted_nxt = 1'b1;
                end else if (cfg_valid) begin
                    piso_load     = 1'b1;
                    word_bits_nxt = '0;
                    state_nxt     = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                // shift_en/ccff_head still go out on an abort cycle; only the
                // loader's own state stops advancing.
                shift_en  = 1'b1;
                ccff_head = piso_q;
                if (abort) begin
                    state_nxt   = ST_IDLE;
                    aborted_nxt = 1'b1;
                end else begin
                    piso_shift    = 1'b1;
                    bit_cnt_nxt   = bit_cnt + CW'(1);
                    word_bits_nxt = word_bits + WCW'(1);
                    // Chain length ends the load even mid-word; leftover bits
                    // of the last word are simply never sent.
                    if (bit_cnt == CW'(CHAIN_LEN - 1))
                        state_nxt = ST_DONE;
                    else if (word_bits == WCW'(WORD_W - 1))
                        state_nxt = ST_FETCH;
                end
            end

            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end

            default: state_nxt = ST_IDLE;
        endcase
    end

    assign busy    = (state != ST_IDLE);
    assign aborted = aborted_q;

endmodule

// File: tb/tb_ccff_loader.sv
// Directed bench: two loaders (12-bit and 16-bit chains, 8-bit words) share
// all inputs, so both fetch their two words on the same cycles.
module tb_ccff_loader;

    logic       prog_clk = 1'b0;
    logic       pReset = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [7:0] cfg_data = 8'h00;
    logic       tail = 1'b0;

    logic a_cfg_ready, a_ccff_head, a_shift_en, a_busy, a_done, a_aborted;
    logic b_cfg_ready, b_ccff_head, b_shift_en, b_busy, b_done, b_aborted;

    always #5 prog_clk = ~prog_clk;

    ccff_loader #(.CHAIN_LEN(12), .WORD_W(8)) u_a (
        .prog_clk (prog_clk), .pReset (pReset), .start (start), .abort (abort),
        .cfg_valid (cfg_valid), .cfg_data (cfg_data), .cfg_ready (a_cfg_ready),
        .ccff_head (a_ccff_head), .ccff_tail (tail), .shift_en (a_shift_en),
        .busy (a_busy), .done (a_done), .aborted (a_aborted)
    );

    ccff_loader #(.CHAIN_LEN(16), .WORD_W(8)) u_b (
        .prog_clk (prog_clk), .pReset (pReset), .start (start), .abort (abort),
        .cfg_valid (cfg_valid), .cfg_data (cfg_data), .cfg_ready (b_cfg_ready),
        .ccff_head (b_ccff_head), .ccff_tail (tail), .shift_en (b_shift_en),
        .busy (b_busy), .done (b_done), .aborted (b_aborted)
    );

    // Chain model: each shift pushes ccff_head in at bit 0, so after a full
    // load the first bit sent sits in the MSB.
    logic        mon_clr = 1'b0;
    logic [11:0] sr_a, heads_a;
    logic [15:0] sr_b;
    int          sh_a, sh_b, done_a, done_b, abt_a, abt_b;

    always @(negedge prog_clk) begin
        if (mon_clr) begin
            sr_a = '0; sr_b = '0; heads_a = '0;
            sh_a = 0; sh_b = 0; done_a = 0; done_b = 0; abt_a = 0; abt_b = 0;
        end else begin
            if (a_shift_en) begin
                if (sh_a < 12) heads_a[sh_a] = a_ccff_head;
                sr_a = {sr_a[10:0], a_ccff_head};
                sh_a++;
            end
            if (b_shift_en) begin
                sr_b = {sr_b[14:0], b_ccff_head};
                sh_b++;
            end
            if (a_done) done_a++;
            if (b_done) done_b++;
            if (a_aborted) abt_a++;
            if (b_aborted) abt_b++;
        end
    end

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge prog_clk);
        #1;
        tail = 1'($urandom_range(0, 1));
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        tick();
        mon_clr = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input int stall);
        int n = 0;
        cfg_valid = 1'b0;
        while (!(a_cfg_ready && b_cfg_ready) && n < 200) begin
            tick();
            n++;
        end
        chk("fetch_reached", 32'(n < 200), 32'd1);
        for (int k = 0; k < stall; k++) begin
            tick();
            chk("stall_shift_a", 32'(a_shift_en), 32'd0);
            chk("stall_shift_b", 32'(b_shift_en), 32'd0);
            chk("stall_ready_b", 32'(b_cfg_ready), 32'd1);
        end
        cfg_valid = 1'b1;
        cfg_data  = w;
        tick();
        cfg_valid = 1'b0;
        cfg_data  = 8'($urandom_range(0, 255));
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((a_busy || b_busy) && n < 200) begin
            tick();
            n++;
        end
        chk("idle_reached", 32'(n < 200), 32'd1);
    endtask

    task automatic do_load(input logic [7:0] w1, input logic [7:0] w2, input int stall2);
        clear_mon();
        start = 1'b1;
        tick();
        start = 1'b0;
        send_word(w1, 0);
        send_word(w2, stall2);
        wait_idle();
        tick();
    endtask

    initial begin
        // Reset state
        pReset = 1'b0;
        tick();
        tick();
        chk("rst_ready",   32'({a_cfg_ready, b_cfg_ready}), 32'd0);
        chk("rst_head",    32'({a_ccff_head, b_ccff_head}), 32'd0);
        chk("rst_shift",   32'({a_shift_en, b_shift_en}),   32'd0);
        chk("rst_busy",    32'({a_busy, b_busy}),           32'd0);
        chk("rst_done",    32'({a_done, b_done}),           32'd0);
        chk("rst_aborted", 32'({a_aborted, b_aborted}),     32'd0);
        pReset = 1'b1;
        tick();

        // Abort while idle does nothing
        abort = 1'b1;
        tick();
        chk("idle_abort_pulse", 32'({a_aborted, b_aborted}), 32'd0);
        chk("idle_abort_busy",  32'({a_busy, b_busy}),       32'd0);
        abort = 1'b0;

        // Basic load: 0xA5 then 0x03
        do_load(8'hA5, 8'h03, 0);
        chk("l1_heads_a", 32'(heads_a), 32'h3A5);
        chk("l1_shifts_a", 32'(sh_a), 32'd12);
        chk("l1_shifts_b", 32'(sh_b), 32'd16);
        chk("l1_chain_a", 32'(sr_a), 32'hA5C);
        chk("l1_chain_b", 32'(sr_b), 32'hA5C0);
        chk("l1_done_a", 32'(done_a), 32'd1);
        chk("l1_done_b", 32'(done_b), 32'd1);
        chk("l1_abt_a",  32'(abt_a),  32'd0);

        // Host stalls 5 cycles before the second word
        do_load(8'hA5, 8'h03, 5);
        chk("l2_shifts_b", 32'(sh_b), 32'd16);
        chk("l2_chain_b", 32'(sr_b), 32'hA5C0);
        chk("l2_chain_a", 32'(sr_a), 32'hA5C);
        chk("l2_done_b", 32'(done_b), 32'd1);

        // Abort after three shifts
        clear_mon();
        start = 1'b1;
        tick();
        start = 1'b0;
        send_word(8'hA5, 0);
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_pulse", 32'({a_aborted, b_aborted}), 32'h3);
        chk("ab_busy",  32'({a_busy, b_busy}),       32'd0);
        tick();
        chk("ab_pulse_end", 32'({a_aborted, b_aborted}), 32'd0);
        tick();
        tick();
        chk("ab_shifts_a", 32'(sh_a), 32'd3);
        chk("ab_count_a",  32'(abt_a), 32'd1);
        chk("ab_count_b",  32'(abt_b), 32'd1);
        chk("ab_no_done",  32'(done_a + done_b), 32'd0);

        // start held high mid-SHIFT is ignored
        clear_mon();
        start = 1'b1;
        tick();
        start = 1'b0;
        send_word(8'hA5, 0);
        start = 1'b1;
        tick();
        chk("st_busy",  32'({a_busy, b_busy}),         32'h3);
        chk("st_shift", 32'({a_shift_en, b_shift_en}), 32'h3);
        tick();
        tick();
        start = 1'b0;
        send_word(8'h03, 0);
        wait_idle();
        tick();
        chk("st_shifts_a", 32'(sh_a), 32'd12);
        chk("st_shifts_b", 32'(sh_b), 32'd16);
        chk("st_chain_b",  32'(sr_b), 32'hA5C0);
        chk("st_done_a",   32'(done_a), 32'd1);

        // Reset mid-SHIFT, then a fresh load
        clear_mon();
        start = 1'b1;
        tick();
        start = 1'b0;
        send_word(8'hFF, 0);
        tick();
        abort = 1'b1;
        start = 1'b1;
        pReset = 1'b0;
        tick();
        abort = 1'b0;
        start = 1'b0;
        chk("mr_ready",   32'({a_cfg_ready, b_cfg_ready}), 32'd0);
        chk("mr_head",    32'({a_ccff_head, b_ccff_head}), 32'd0);
        chk("mr_shift",   32'({a_shift_en, b_shift_en}),   32'd0);
        chk("mr_busy",    32'({a_busy, b_busy}),           32'd0);
        chk("mr_done",    32'({a_done, b_done}),           32'd0);
        chk("mr_aborted", 32'({a_aborted, b_aborted}),     32'd0);
        pReset = 1'b1;
        tick();
        chk("mr_no_pulse", 32'(abt_a + abt_b + done_a + done_b), 32'd0);
        do_load(8'h3C, 8'h81, 0);
        chk("mr_chain_a",  32'(sr_a), 32'h3C8);
        chk("mr_chain_b",  32'(sr_b), 32'h3C81);
        chk("mr_shifts_b", 32'(sh_b), 32'd16);
        chk("mr_done_b",   32'(done_b), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/ccff_loader.md
CCFF_LOADER -- requirements
Module: ccff_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 64, giving the number of configuration bits in the downstream ccff chain (>=1).
REQ-002 SHALL have parameter WORD_W, default 8, giving the host word width in bits (>=2).
REQ-003 SHALL have port prog_clk, input, 1 bit: the single clock; every flop samples on its rising edge.
REQ-004 SHALL have port pReset, input, 1 bit: the reset, which is synchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: begins a load when sampled high in IDLE.
REQ-006 SHALL have port abort, input, 1 bit: terminates an in-progress load.
REQ-007 SHALL have port cfg_valid, input, 1 bit: the host word is valid.
REQ-008 SHALL have port cfg_data, input, WORD_W bits: the host bitstream word.
REQ-009 SHALL have port cfg_ready, output, 1 bit: the loader accepts a word this cycle.
REQ-010 SHALL have port ccff_head, output, 1 bit: the serial bit driven into the first tile's ccff_head.
REQ-011 SHALL have port ccff_tail, input, 1 bit: the bit returned from the last tile of the chain; it is monitored only.
REQ-012 SHALL have port shift_en, output, 1 bit: the chain advances one bit on the prog_clk edge where this is high.
REQ-013 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-014 SHALL have port done, output, 1 bit: a one-cycle pulse on successful completion.
REQ-015 SHALL have port aborted, output, 1 bit: a one-cycle pulse when a load is terminated by abort.

Function
REQ-016 SHALL implement the states IDLE, FETCH, SHIFT and DONE.
REQ-017 IDLE: start=1 SHALL move to FETCH and clear the bit counter; start SHALL be ignored in every other state.
REQ-018 FETCH: cfg_ready SHALL be 1; a cfg_valid&cfg_ready handshake SHALL load cfg_data into the word register and move to SHIFT next cycle.
REQ-019 SHALL drive cfg_ready=0 in IDLE, SHIFT and DONE; cfg_data SHALL be ignored without a handshake.
REQ-020 SHIFT: each cycle SHALL assert shift_en=1 and drive ccff_head = word register bit 0, then shift the word right by one and increment the bit counter.
REQ-021 Bit order SHALL be LSB first within each word, with words taken in arrival order.
REQ-022 When the bit counter reaches CHAIN_LEN in SHIFT, SHALL move to DONE; the remaining bits of the final word SHALL be discarded.
REQ-023 When WORD_W bits of the current word have been sent and the count is below CHAIN_LEN, SHALL return to FETCH; this gives exactly one bubble per word.
REQ-024 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-025 Outside SHIFT, SHALL hold shift_en=0 and ccff_head=0.
REQ-026 Total shift_en cycles per completed load SHALL equal CHAIN_LEN exactly.
REQ-027 SHALL accept ceil(CHAIN_LEN/WORD_W) words per load.
REQ-028 The bit counter SHALL be $clog2(CHAIN_LEN+1) bits wide and SHALL never wrap.
REQ-029 abort=1 in FETCH or SHIFT SHALL, on the next edge, force IDLE with aborted=1 for one cycle and no done.
REQ-030 abort SHALL take priority over a simultaneous handshake or final shift; abort in IDLE or DONE SHALL have no effect.
REQ-031 If cfg_valid is low in FETCH, the loader SHALL wait indefinitely with shift_en=0.
REQ-032 ccff_tail SHALL have no effect on any output.

Reset
REQ-033 pReset=0 at a prog_clk edge SHALL force IDLE, clear the counter and word register, and drive cfg_ready, ccff_head, shift_en, busy, done and aborted to 0.
REQ-034 Reset mid-load SHALL discard the load with no done and no aborted pulse; reset SHALL take priority over abort and start.

Structure
REQ-035 Package ccff_pkg SHALL hold the state enum type and the default WORD_W constant.
REQ-036 Sub-module ccff_piso SHALL implement the WORD_W parallel-load, right-shift register with load and shift enables; the FSM and counter SHALL live in ccff_loader.

Verification
REQ-037 CHAIN_LEN=12, WORD_W=8, words 0xA5 then 0x03: ccff_head on shift_en cycles SHALL be 1,0,1,0,0,1,0,1,1,1,0,0; shift_en SHALL be high for 12 cycles; done SHALL pulse once.
REQ-038 CHAIN_LEN=16, with cfg_valid withheld 5 cycles before word 2: shift_en SHALL stay 0 throughout the stall and the total shift count SHALL remain 16.
REQ-039 abort asserted after 3 shift cycles: aborted SHALL pulse once, busy SHALL drop next cycle, and no done SHALL occur.
REQ-040 start re-asserted during SHIFT: SHALL have no effect on state or count.
REQ-041 pReset=0 mid-SHIFT: all outputs SHALL read 0 next cycle; a fresh load SHALL then complete normally.
REQ-042 A scoreboard SHALL model a CHAIN_LEN shift register on shift_en/ccff_head and match the intended bitstream at each done.
